// File: rtl/fifo_write_burst_if.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_write_burst_if
//  Description : FIFO port bundle. The master side produces writes and
//                strobes, the slave side is the FIFO itself.
//  Revision    : 1.0  initial release
// ============================================================================
interface fifo_write_burst_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] in_data;
    logic             read_valid;
    logic             rst;
    logic             write_valid;
    logic [WIDTH-1:0] out_data;
    logic             read_ready;
    logic             write_ready;

    modport master (
        output in_data, read_valid, rst, write_valid,
        input  out_data, read_ready, write_ready
    );

    modport slave (
        input  in_data, read_valid, rst, write_valid,
        output out_data, read_ready, write_ready
    );
endinterface
`default_nettype wire

// File: rtl/fifo_write_burst.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_write_burst
//  Description : Pushes arg_2 consecutive words starting at arg_1 into an
//                external FIFO, one word per two cycles at most, then reports
//                the number of words written on return_value with valid.
//  Revision    : 1.0  initial release
// ============================================================================
module fifo_write_burst #(
    parameter int WIDTH       = 32,
    parameter int COUNT_WIDTH = 32
) (
    input  wire logic                   clk,
    input  wire logic                   rst,
    fifo_write_burst_if.master          arg_0,
    input  wire logic [WIDTH-1:0]       arg_1,
    input  wire logic [COUNT_WIDTH-1:0] arg_2,
    output logic      [WIDTH-1:0]       return_value,
    output logic                        valid
);

    localparam logic [1:0] S_LOAD = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_PUSH = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [COUNT_WIDTH-1:0] c_count_zero = '0;
    localparam logic [COUNT_WIDTH-1:0] c_count_one  = COUNT_WIDTH'(1);

    logic [1:0]             r_state;
    logic [1:0]             w_state_next;
    logic [WIDTH-1:0]       r_base;
    logic [COUNT_WIDTH-1:0] r_count;
    logic [COUNT_WIDTH-1:0] r_idx;
    logic [COUNT_WIDTH-1:0] w_idx_inc;
    logic [WIDTH-1:0]       w_idx_w;
    logic                   w_unused_ok;

    // Read-side inputs of the bundle are not needed by a pure writer.
    assign w_unused_ok = ^{arg_0.out_data, arg_0.read_ready};

    // idx never wraps because it stops at count, which fits COUNT_WIDTH.
    assign w_idx_inc = r_idx + c_count_one;

    // Resize the word index to the data width (zero-extend or truncate).
    generate
        if (WIDTH >= COUNT_WIDTH) begin : g_idx_zext
            assign w_idx_w = {{(WIDTH-COUNT_WIDTH){1'b0}}, r_idx};
        end else begin : g_idx_trunc
            assign w_idx_w = r_idx[WIDTH-1:0];
        end
    endgenerate

    // State register plus the burst context (base, count, word index).
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_LOAD;
            r_base  <= '0;
            r_count <= '0;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_next;
            case (r_state)
                S_LOAD: begin
                    r_base  <= arg_1;
                    r_count <= arg_2;
                    r_idx   <= '0;
                end
                S_PUSH:  r_idx <= w_idx_inc;
                default: ;
            endcase
        end
    end

    // Next-state logic; a word is only strobed after ready was seen high.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_LOAD:  w_state_next = (arg_2 == c_count_zero) ? S_DONE : S_WAIT;
            S_WAIT:  w_state_next = arg_0.write_ready ? S_PUSH : S_WAIT;
            S_PUSH:  w_state_next = (w_idx_inc == r_count) ? S_DONE : S_WAIT;
            S_DONE:  w_state_next = S_DONE;
            default: w_state_next = S_LOAD;
        endcase
    end

    // Moore outputs decoded from state, forced quiet while reset is high.
    always_comb begin
        arg_0.write_valid = 1'b0;
        arg_0.in_data     = '0;
        valid             = 1'b0;
        return_value      = '0;
        if (!rst) begin
            if (r_state == S_PUSH) begin
                arg_0.write_valid = 1'b1;
                arg_0.in_data     = r_base + w_idx_w;
            end
            if (r_state == S_DONE) begin
                valid        = 1'b1;
                return_value = w_idx_w;
            end
        end
    end

    assign arg_0.read_valid = 1'b0;
    assign arg_0.rst        = 1'b0;

endmodule
`default_nettype wire

// File: tb/tb_fifo_write_burst.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fifo_write_burst
//  Description : Directed bench for fifo_write_burst. Each scenario lists the
//                cycles in which words are expected and the cycle valid rises.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_fifo_write_burst;

    localparam int WIDTH = 32;

    logic             clk;
    logic             rst;
    logic [WIDTH-1:0] arg_1;
    logic [WIDTH-1:0] arg_2;
    logic [WIDTH-1:0] return_value;
    logic             valid;

    int n_cmp;
    int n_mis;

    // Per-scenario expectation table: cycles of each push, ready mask.
    int          exp_pc[$];
    logic [31:0] rdy_mask;

    fifo_write_burst_if #(.WIDTH(WIDTH)) arg_0_if ();

    fifo_write_burst #(
        .WIDTH       (WIDTH),
        .COUNT_WIDTH (WIDTH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .arg_0        (arg_0_if.master),
        .arg_1        (arg_1),
        .arg_2        (arg_2),
        .return_value (return_value),
        .valid        (valid)
    );

    // 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reset, release with the given args, then check ncyc cycles.
    // In cycle abort_at (if >= 0) reset is asserted again and the run ends.
    task automatic run_test(input string name, input logic [31:0] base, input logic [31:0] n,
                            input int done_cyc, input int ncyc, input int abort_at);
        logic prev_ready;
        int   k;
        logic       e_wv, e_v;
        logic [31:0] e_d, e_r;
        rst = 1'b1;
        arg_0_if.write_ready = 1'b0;
        @(negedge clk);
        rst   = 1'b0;
        arg_1 = base;
        arg_2 = n;
        prev_ready = 1'b0;
        for (int c = 0; c < ncyc; c++) begin
            arg_0_if.write_ready = (c < 32) ? rdy_mask[c] : 1'b1;
            if (c >= 1) begin
                arg_1 = ~base;
                arg_2 = 32'd99;
            end
            if (c == abort_at) rst = 1'b1;
            #1;
            e_wv = 1'b0;
            e_d  = '0;
            k    = -1;
            for (int j = 0; j < exp_pc.size(); j++)
                if (exp_pc[j] == c) k = j;
            if (k >= 0 && c != abort_at) begin
                e_wv = 1'b1;
                e_d  = base + k;
            end
            e_v = (c >= done_cyc) && (abort_at < 0);
            e_r = e_v ? n : 32'd0;
            check($sformatf("%s c%0d write_valid", name, c), {31'd0, arg_0_if.write_valid}, {31'd0, e_wv});
            check($sformatf("%s c%0d in_data", name, c), arg_0_if.in_data, e_d);
            check($sformatf("%s c%0d valid", name, c), {31'd0, valid}, {31'd0, e_v});
            check($sformatf("%s c%0d return_value", name, c), return_value, e_r);
            check($sformatf("%s c%0d tied", name, c),
                  {30'd0, arg_0_if.read_valid, arg_0_if.rst}, 32'd0);
            check($sformatf("%s c%0d strobe_without_ready", name, c),
                  {31'd0, arg_0_if.write_valid & ~prev_ready}, 32'd0);
            prev_ready = arg_0_if.write_ready;
            if (c == abort_at) return;
            @(negedge clk);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_mis = 0;
        rst   = 1'b1;
        arg_1 = '0;
        arg_2 = '0;
        arg_0_if.out_data    = '0;
        arg_0_if.read_ready  = 1'b0;
        arg_0_if.write_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("reset write_valid", {31'd0, arg_0_if.write_valid}, 32'd0);
        check("reset in_data", arg_0_if.in_data, 32'd0);
        check("reset valid", {31'd0, valid}, 32'd0);
        check("reset return_value", return_value, 32'd0);

        // Three words, ready held high: strobes 2,4,6, valid from 7.
        rdy_mask = 32'hFFFF_FFFF;
        exp_pc = '{2, 4, 6};
        run_test("basic", 32'd10, 32'd3, 7, 10, -1);

        // Zero words: valid from cycle 1, never a strobe.
        exp_pc = {};
        run_test("empty", 32'd7, 32'd0, 1, 5, -1);

        // Ready low cycles 0-5: strobes 7 and 9, valid from 10.
        rdy_mask = 32'hFFFF_FFC0;
        exp_pc = '{7, 9};
        run_test("backpressure", 32'd5, 32'd2, 10, 13, -1);

        // Ready toggling between words: low in cycles 2-4 -> strobes 2 and 6.
        rdy_mask = ~32'h0000_001C;
        exp_pc = '{2, 6};
        run_test("toggle", 32'd40, 32'd2, 7, 9, -1);

        // Data wraps modulo 2^32.
        rdy_mask = 32'hFFFF_FFFF;
        exp_pc = '{2, 4, 6};
        run_test("wrap", 32'hFFFF_FFFE, 32'd3, 7, 9, -1);

        // Reset during the second push of a four-word burst, then restart.
        exp_pc = '{2, 4, 6, 8};
        run_test("abort", 32'd100, 32'd4, 9, 6, 4);
        exp_pc = '{2, 4};
        run_test("restart", 32'd200, 32'd2, 5, 8, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
`default_nettype wire
